// File: rtl/mealy_arbiter.sv
// rtl/mealy_arbiter.sv - round-robin sharing of a serial Mealy run-end detector between two requesters
// Optional MEALY_FLUSH_EN adds a FLUSH cycle so a trailing run of 1s is counted.
module mealy_arbiter #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [W-1:0]  din0,
  input  logic          req1,
  input  logic [W-1:0]  din1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          ack0,
  output logic          ack1,
  output logic [CW-1:0] cnt
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
`ifdef MEALY_FLUSH_EN
  localparam logic [1:0] FLUSH = 2'b10;
`endif
  localparam logic [1:0] DONE  = 2'b11;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S3 = 2'b11;
  localparam logic [1:0] S2 = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    det_q, det_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          last_q, last_d;

  logic       x, y, pick1;
  logic [1:0] det_n;
  logic [CW-1:0] cnt_inc;

  // FLUSH (when built) sees x=0 because only SHIFT feeds the shift-register MSB
  assign x = (state_q == SHIFT) ? sr_q[W-1] : 1'b0;
  assign y = ~x & (det_q != S0);
  assign pick1 = req1 & (~req0 | ~last_q);
  assign cnt_inc = (y && cnt_q != CNT_MAX) ? cnt_q + CW'(1) : cnt_q;

  always_comb begin
    det_n = S0;
    if (x) begin
      case (det_q)
        S0:      det_n = S1;
        S1:      det_n = S3;
        S3:      det_n = S2;
        default: det_n = S2;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    det_d   = det_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = SHIFT;
          sr_d    = pick1 ? din1 : din0;
          det_d   = S0;
          idx_d   = '0;
          cnt_d   = '0;
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        det_d = det_n;
        cnt_d = cnt_inc;
        sr_d  = {sr_q[W-2:0], 1'b0};
        idx_d = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
`ifdef MEALY_FLUSH_EN
          state_d = FLUSH;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MEALY_FLUSH_EN
      FLUSH: begin
        det_d   = det_n;
        cnt_d   = cnt_inc;
        state_d = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      det_q   <= S0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;
  assign ack0 = (state_q == DONE) & gnt_q[0];
  assign ack1 = (state_q == DONE) & gnt_q[1];

endmodule

// File: tb/tb_mealy_arbiter.sv
// tb/tb_mealy_arbiter.sv - self-checking bench for mealy_arbiter (CW=4 and saturating CW=2 instances)
module tb_mealy_arbiter;

  localparam int W = 8;
`ifdef MEALY_FLUSH_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif
  localparam int LAT = W + 1 + FL;

  logic         clk, rst;
  logic         req0, req1;
  logic [W-1:0] din0, din1;
  logic [1:0]   gnt, gnt_s;
  logic         busy, busy_s, ack0, ack0_s, ack1, ack1_s;
  logic [3:0]   cnt;
  logic [1:0]   cnt_s;

  int tests = 0;
  int fails = 0;
  bit model_last = 1'b1;

  mealy_arbiter #(.W(W), .CW(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .gnt(gnt), .busy(busy), .ack0(ack0), .ack1(ack1), .cnt(cnt)
  );

  mealy_arbiter #(.W(W), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .gnt(gnt_s), .busy(busy_s), .ack0(ack0_s), .ack1(ack1_s), .cnt(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count "1 then 0" boundaries in the MSB-first bit stream, plus a trailing 1-run when flushing.
  function automatic int run_ends(input logic [W-1:0] w, input int maxv);
    int c = 0;
    bit prev = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!w[i] && prev) c++;
      prev = w[i];
    end
    if (FL != 0 && prev) c++;
    if (c > maxv) c = maxv;
    return c;
  endfunction

  function automatic bit pick1();
    return req1 && (!req0 || !model_last);
  endfunction

  // Caller leaves the DUT idle at a negedge with requests set; returns at the next idle negedge.
  task automatic run_word(input int exp_c, input int exp_cs, input string tag, output logic [1:0] seen_g);
    logic [1:0] exp_g;
    int acks = 0;
    int ack_at = -1;
    bit bad_gnt = 1'b0;
    exp_g = pick1() ? 2'b10 : 2'b01;
    model_last = exp_g[1];
    seen_g = 2'b00;
    @(posedge clk);
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      if (n == 1) seen_g = gnt;
      if (gnt === 2'b11 || gnt_s === 2'b11) bad_gnt = 1'b1;
      if (n <= LAT && (gnt !== exp_g || busy !== 1'b1)) bad_gnt = 1'b1;
      if (ack0 || ack1) begin
        acks++;
        ack_at = n;
        tests++;
        if ({ack1, ack0} !== exp_g) begin
          fails++;
          $display("FAIL %s ack_sel: got %b want %b", tag, {ack1, ack0}, exp_g);
        end
        tests++;
        if (cnt !== 4'(exp_c) || cnt_s !== 2'(exp_cs)) begin
          fails++;
          $display("FAIL %s cnt_done: got %0d/%0d want %0d/%0d", tag, cnt, cnt_s, exp_c, exp_cs);
        end
        if (exp_g[0]) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    tests++;
    if (acks != 1 || ack_at != LAT) begin
      fails++;
      $display("FAIL %s ack_timing: got %0d acks at cycle %0d want 1 at %0d", tag, acks, ack_at, LAT);
    end
    tests++;
    if (bad_gnt) begin
      fails++;
      $display("FAIL %s gnt_busy_hold: gnt/busy wrong during word, want gnt %b", tag, exp_g);
    end
    tests++;
    if (gnt !== 2'b00 || busy !== 1'b0 || cnt !== 4'(exp_c) || cnt_s !== 2'(exp_cs)) begin
      fails++;
      $display("FAIL %s idle_after: got gnt %b busy %b cnt %0d/%0d want 00 0 %0d/%0d",
               tag, gnt, busy, cnt, cnt_s, exp_c, exp_cs);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({gnt, busy, ack0, ack1, cnt} !== 9'd0 || {gnt_s, busy_s, ack0_s, ack1_s, cnt_s} !== 7'd0) begin
      fails++;
      $display("FAIL reset_state: got gnt %b busy %b ack %b%b cnt %0d want all zero", gnt, busy, ack1, ack0, cnt);
    end
    rst = 1'b0;
  endtask

  task automatic single0(input logic [W-1:0] w, input int exp_c, input int exp_cs, input string tag);
    logic [1:0] g;
    din0 = w;
    req0 = 1'b1;
    run_word(exp_c, exp_cs, tag, g);
    tests++;
    if (g !== 2'b01) begin
      fails++;
      $display("FAIL %s gnt: got %b want 01", tag, g);
    end
  endtask

  task automatic test_directed();
    single0(8'b0110_0110, 2, 2, "d_0110");
    single0(8'b1010_1011, 3 + FL, 3, "d_1010_1011");
    single0(8'hFF, FL, FL, "d_ff");
    single0(8'h00, 0, 0, "d_00");
  endtask

  task automatic test_saturate();
    single0(8'b1010_1010, 4, 3, "sat");
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    din0 = $urandom; din1 = $urandom;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_word(run_ends(pick1() ? din1 : din0, 15), run_ends(pick1() ? din1 : din0, 3), "rr", g);
      tests++;
      if (g !== order[i]) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %b want %b", i, g, order[i]);
      end
      req0 = 1'b1; req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    din0 = 8'b1010_1010;
    req0 = 1'b1;
    void'(pick1());
    @(posedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (gnt !== 2'b00 || busy !== 1'b0 || cnt !== 4'd0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: got gnt %b busy %b cnt %0d ack %b%b want 00 0 0 00", gnt, busy, cnt, ack1, ack0);
    end
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    din1 = 8'b0100_0000;
    req1 = 1'b1;
    run_word(1, 1, "rst_recover", g);
    tests++;
    if (g !== 2'b10) begin
      fails++;
      $display("FAIL rst_recover gnt: got %b want 10", g);
    end
  endtask

  task automatic test_random();
    logic [1:0] g;
    logic [W-1:0] w;
    for (int i = 0; i < 24; i++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin din0 = $urandom; req0 = 1'b1; end
      if (!req1 && $urandom_range(0, 1) == 1) begin din1 = $urandom; req1 = 1'b1; end
      if (!req0 && !req1) begin
        if ($urandom_range(0, 1) == 1) begin din1 = $urandom; req1 = 1'b1; end
        else begin din0 = $urandom; req0 = 1'b1; end
      end
      w = pick1() ? din1 : din0;
      run_word(run_ends(w, 15), run_ends(w, 3), "rand", g);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_directed();
    test_saturate();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mealy_arbiter.md
# mealy_arbiter

Shares one serial Mealy run-end detector between two requesters on a round-robin basis. Each requester hands over a W-bit word with a req/ack handshake. The block:
- serializes the granted word MSB-first into the detector,
- counts detector output pulses,
- returns the count with a one-cycle acknowledge.

It is the sequencing/arbitration layer for the detector datapath in the sequential-logic section.

## Interface
- W, default 8: word width in bits, minimum 2.
- CW, default 4: count width; count saturates at 2^CW-1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high. One clock domain; reset is asynchronous and active-high.
- req0  input  1  requester 0 request level.
- din0  input  W  requester 0 word, held stable while req0 is high.
- req1  input  1  requester 1 request level.
- din1  input  W  requester 1 word, held stable while req1 is high.
- gnt  output  2  one-hot grant; bit i is high from load through DONE.
- busy  output  1  high in SHIFT, FLUSH and DONE.
- ack0  output  1  one-cycle pulse in DONE when requester 0 is served.
- ack1  output  1  one-cycle pulse in DONE when requester 1 is served.
- cnt  output  CW  run-end count of the last served word.

## Operation
- **Detector (internal, registered state D, combinational y).** States: S0=00, S1=01, S3=11, S2=10.
  - On x=1: S0→S1, S1→S3, S3→S2, S2→S2.
  - On x=0: any state→S0.
  - y = ~x & (D≠S0). y marks a 0 that terminates a run of one or more 1s.
- **Controller states:** IDLE, SHIFT, FLUSH (only with the macro, see Configuration), DONE.
- **IDLE**
  - If any req is high, arbitrate.
  - Load the shift register with the winner's din.
  - D←S0, bit index←0, cnt←0, gnt←winner.
  - Next state: SHIFT.
- **Round-robin.**
  - Pointer `last` holds the last-served requester; reset value 1, so req0 wins the first tie.
  - On a tie, grant the requester ≠ last.
  - A single requester is always granted.
  - `last` updates at load.
- **SHIFT**
  - x = shift-register MSB.
  - Each cycle: D advances; if y=1, cnt←cnt+1, saturating at 2^CW-1 with no wrap; shift left by 1; index+1.
  - After W bits: go to FLUSH if the macro is enabled, else DONE.
- **DONE**
  - ack for the granted requester = 1 for exactly this cycle.
  - gnt cleared at exit.
  - Next state: IDLE.
- **Result hold.** cnt holds the DONE value until the next load clears it.
- **Handshake.**
  - din is sampled only at the load edge.
  - The requester must have req low at the first IDLE cycle after its ack. A req still high there is treated as a new request.
  - req falling while the requester is being served is ignored; the word completes and ack is still issued.
- **Reset.**
  - Values: gnt=00, busy=0, ack0=ack1=0, cnt=0, D=S0, state IDLE, last=1.
  - Reset mid-operation aborts immediately: no ack and no partial count.

## Timing
- Request sampled at edge k (IDLE).
- SHIFT occupies cycles k+1..k+W.
- Without the macro: DONE/ack in cycle k+W+1, next IDLE at k+W+2.
- With the macro: DONE/ack in cycle k+W+2, next IDLE at k+W+3.
- Minimum spacing between successive loads: W+2 cycles (W+3 with the macro).
- cnt is valid from the DONE cycle onward; it is stable during DONE.
- All outputs are registered except that ack is decoded from state and grant, so it is glitch-free at the edge.

## Configuration
- **MEALY_FLUSH_EN defined:**
  - A FLUSH cycle after the last SHIFT drives x=0 for one detector step.
  - A trailing run of 1s at the word's LSB end is therefore counted.
  - Latency increases by 1.
- **MEALY_FLUSH_EN undefined:**
  - No FLUSH state.
  - A trailing run of 1s is not counted.

## Test plan
- W=8, req0 only, din0=8'b0110_0110, macro off → gnt=01; ack0 pulse at k+9; cnt=2.
- din0=8'b1010_1011 → cnt=3 with the macro off (ack at k+9); cnt=4 with MEALY_FLUSH_EN (ack at k+10).
- din0=8'hFF → cnt=0 with the macro off; cnt=1 with the macro on. din0=8'h00 → cnt=0 in both builds.
- After reset, req0 and req1 both held high continuously, each dropped for one cycle after its ack → grant order 0,1,0,1. Exactly one ack per word; gnt never 11.
- rst pulsed in SHIFT at k+4 → same cycle: gnt=00, busy=0, cnt=0, no ack. A following req1 with 8'b0100_0000 → cnt=1.
- CW=2, din0=8'b1010_1010 → cnt saturates at 3; the fourth run end does not wrap the count to 0.
